// File: rtl/nativefifo2axis_pkg.sv
// Shared constants for the native-FIFO to AXI4-Stream reader bridge.
package nativefifo2axis_pkg;

  // Output skid buffer depth; covers the two-cycle read pipeline plus one
  // extra slot so a stalled consumer never forces a dropped word.
  localparam int BUF_DEPTH  = 3;
  // Occupancy width, enough for 0..BUF_DEPTH.
  localparam int OCC_W      = 2;
  // Width of the optional packet beat counter.
  localparam int BEAT_CNT_W = 16;

  typedef logic [OCC_W-1:0] occ_t;

endpackage

// File: rtl/nativefifo2axis_axis_out_buf.sv
// axis_out_buf: small register FIFO feeding the AXI-Stream master outputs.
// Entry 0 is always the head, so tdata/tvalid come straight from flops.
module axis_out_buf
  import nativefifo2axis_pkg::*;
#(
  parameter int DW = 24
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  output logic [DW-1:0] head_o,
  output logic          valid_o,
  output occ_t          occ_o
);

  logic [DW-1:0] mem_q [BUF_DEPTH];
  logic [DW-1:0] mem_d [BUF_DEPTH];
  occ_t          occ_q;
  occ_t          occ_d;
  occ_t          wr_idx;
  logic          pop_eff;
  logic          push_eff;

  // Next-state: shift toward the head on pop, write behind the last valid entry on push.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    mem_d    = mem_q;
    occ_d    = occ_q;
    wr_idx   = occ_q;
    pop_eff  = pop_i && (occ_q != '0);
    push_eff = push_i && (pop_eff || (occ_q < occ_t'(BUF_DEPTH)));

    if (pop_eff) begin
      for (int i = 0; i < BUF_DEPTH - 1; i++) begin
        mem_d[i] = mem_q[i+1];
      end
      wr_idx = occ_q - occ_t'(1);
    end

    if (push_eff) begin
      mem_d[wr_idx] = push_data_i;
    end

    case ({push_eff, pop_eff})
      2'b10:   occ_d = occ_q + occ_t'(1);
      2'b01:   occ_d = occ_q - occ_t'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the entries are reset (not left uninitialised) because entry 0 drives tdata, which must read 0 out of reset.
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      occ_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      mem_q <= mem_d;
      occ_q <= occ_d;
    end
  end

  assign head_o  = mem_q[0];
  assign valid_o = (occ_q != '0);
  assign occ_o   = occ_q;

endmodule

// File: rtl/nativefifo2axis.sv
// nativefifo2axis: pops a standard-mode (non-FWFT) native FIFO and presents
// the words as an AXI4-Stream master. Reads are issued from buffer credit
// only, so m_axis_tready has no combinational path to fifo_rd.
// Optional feature macro: NATIVEFIFO2AXIS_TLAST_EN (adds m_axis_tlast every PKT_LEN beats).
module nativefifo2axis
  import nativefifo2axis_pkg::*;
#(
  parameter int DW      = 24,
  parameter int PKT_LEN = 256
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] fifo_dout,
  output logic          fifo_rd,
  input  logic          fifo_empty,
  output logic [DW-1:0] m_axis_tdata,
  output logic          m_axis_tvalid,
  input  logic          m_axis_tready
`ifdef NATIVEFIFO2AXIS_TLAST_EN
  ,
  output logic          m_axis_tlast
`endif
);

  if (PKT_LEN < 1 || PKT_LEN > 65535) begin : g_pkt_len_bad
    $error("nativefifo2axis: PKT_LEN must be in 1..65535");
  end

  logic           inflight_q;
  occ_t           occ;
  logic [OCC_W:0] pending;
  logic           pop;

  // Words already owned by the buffer: stored ones plus the read still in flight.
  assign pending = {1'b0, occ} + {{OCC_W{1'b0}}, inflight_q};
  assign fifo_rd = rst_n && !fifo_empty && (pending < (OCC_W+1)'(BUF_DEPTH));
  assign pop     = m_axis_tvalid && m_axis_tready;

  // Remember last cycle's read so its data is captured when it appears on fifo_dout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= fifo_rd;
    end
  end

  axis_out_buf #(.DW(DW)) u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (inflight_q),
    .push_data_i (fifo_dout),
    .pop_i       (pop),
    .head_o      (m_axis_tdata),
    .valid_o     (m_axis_tvalid),
    .occ_o       (occ)
  );

`ifdef NATIVEFIFO2AXIS_TLAST_EN
  logic [BEAT_CNT_W-1:0] beat_cnt_q;
  logic [BEAT_CNT_W-1:0] beat_cnt_d;
  logic                  last_beat;

  // Count accepted beats; the count always refers to the current head beat.
  always_comb begin
    last_beat  = (beat_cnt_q == BEAT_CNT_W'(PKT_LEN - 1));
    beat_cnt_d = beat_cnt_q;
    if (pop) begin
      beat_cnt_d = last_beat ? '0 : beat_cnt_q + 1'b1;
    end
  end

  // Beat counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Only changes on a handshake, so it holds steady during a stall.
  assign m_axis_tlast = m_axis_tvalid && last_beat;
`endif

endmodule

// File: tb/tb_nativefifo2axis.sv
// Directed bench for nativefifo2axis with a behavioural standard-mode FIFO.
module tb_nativefifo2axis;

  localparam int DW      = 24;
  localparam int PKT_LEN = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] fifo_dout = '0;
  logic          fifo_rd;
  logic          fifo_empty;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic          m_axis_tlast;

  int checks = 0;
  int errors = 0;

  // Behavioural FIFO: words pushed by the tasks, popped one cycle after fifo_rd.
  logic [DW-1:0] fifo_mem [$];
  int            fifo_pushed = 0;
  int            fifo_popped = 0;
  logic          hold_empty = 1'b1;

  // Monitor state.
  logic [DW-1:0] rx_q [$];
  logic          rx_last [$];
  int            rd_cnt = 0;
  int            hs_cnt = 0;
  logic          stall_prev = 1'b0;
  logic [DW-1:0] stall_data = '0;
  logic          stall_last = 1'b0;

  always #5 clk = ~clk;

  assign fifo_empty = hold_empty || (fifo_pushed == fifo_popped);

  nativefifo2axis #(.DW(DW), .PKT_LEN(PKT_LEN)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fifo_dout     (fifo_dout),
    .fifo_rd       (fifo_rd),
    .fifo_empty    (fifo_empty),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready)
`ifdef NATIVEFIFO2AXIS_TLAST_EN
    ,
    .m_axis_tlast  (m_axis_tlast)
`endif
  );

`ifndef NATIVEFIFO2AXIS_TLAST_EN
  assign m_axis_tlast = 1'b0;
`endif

  always @(posedge clk) begin
    if (fifo_rd) begin
      fifo_dout   <= fifo_mem.pop_front();
      fifo_popped <= fifo_popped + 1;
    end
  end

  // Per-cycle monitor: credit bound, AXI stability, handshake capture.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (rd_cnt - hs_cnt > 3) begin
        errors++;
        $display("FAIL occ_plus_inflight: got %0d, need <= 3", rd_cnt - hs_cnt);
      end
      if (stall_prev) begin
        checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== stall_data || m_axis_tlast !== stall_last) begin
          errors++;
          $display("FAIL axi_stable: got v=%b d=%h l=%b, need v=1 d=%h l=%b",
                   m_axis_tvalid, m_axis_tdata, m_axis_tlast, stall_data, stall_last);
        end
      end
      if (fifo_rd) rd_cnt++;
      if (m_axis_tvalid && m_axis_tready) begin
        rx_q.push_back(m_axis_tdata);
        rx_last.push_back(m_axis_tlast);
        hs_cnt++;
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
      stall_data = m_axis_tdata;
      stall_last = m_axis_tlast;
    end else begin
      stall_prev = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic clear_env();
    fifo_mem.delete();
    fifo_pushed = fifo_popped;
    rx_q.delete();
    rx_last.delete();
    rd_cnt = 0;
    hs_cnt = 0;
  endtask

  task automatic load(input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      fifo_mem.push_back(base + DW'(i));
      fifo_pushed++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_axis_tready = 1'b0;
    hold_empty = 1'b1;
    clear_env();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    m_axis_tready = 1'b0;
    clear_env();
    load(24'h00A000, 5);
    hold_empty = 1'b0;
    #2;
    checks++;
    if (fifo_rd !== 1'b0 || m_axis_tvalid !== 1'b0 || m_axis_tdata !== '0) begin
      errors++;
      $display("FAIL reset_values: got rd=%b v=%b d=%h, need 0 0 000000", fifo_rd, m_axis_tvalid, m_axis_tdata);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 24'h00A000 || fifo_rd !== 1'b0) begin
      errors++;
      $display("FAIL reset_prefill: got v=%b d=%h rd=%b, need 1 00a000 0", m_axis_tvalid, m_axis_tdata, fifo_rd);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (m_axis_tvalid !== 1'b0 || fifo_rd !== 1'b0 || m_axis_tdata !== '0) begin
      errors++;
      $display("FAIL reset_async: got v=%b rd=%b d=%h, need 0 0 000000", m_axis_tvalid, fifo_rd, m_axis_tdata);
    end
    hold_empty = 1'b1;
    clear_env();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (fifo_rd !== 1'b0 || m_axis_tvalid !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle c%0d: got rd=%b v=%b, need 0 0", c, fifo_rd, m_axis_tvalid);
      end
    end
  endtask

  task automatic test_latency();
    do_reset();
    m_axis_tready = 1'b1;
    load(24'h000001, 4);
    @(posedge clk);
    #1 hold_empty = 1'b0;
    for (int c = 0; c < 7; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      @(negedge clk);
      if (c == 0) begin
        checks++;
        if (fifo_rd !== 1'b1) begin
          errors++;
          $display("FAIL latency_rd0: got %b, need 1", fifo_rd);
        end
      end
      checks++;
      if (m_axis_tvalid !== (c >= 2 && c <= 5)) begin
        errors++;
        $display("FAIL latency_valid c%0d: got %b, need %b", c, m_axis_tvalid, (c >= 2 && c <= 5));
      end else if (c >= 2 && c <= 5 && m_axis_tdata !== DW'(c - 1)) begin
        errors++;
        $display("FAIL latency_data c%0d: got %h, need %h", c, m_axis_tdata, DW'(c - 1));
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (hs_cnt !== 4) begin
      errors++;
      $display("FAIL latency_count: got %0d, need 4", hs_cnt);
    end
  endtask

  task automatic test_full_rate();
    int bad;
    do_reset();
    m_axis_tready = 1'b1;
    load(24'h100000, 1000);
    @(posedge clk);
    #1 hold_empty = 1'b0;
    repeat (1002) @(posedge clk);
    #1;
    checks++;
    if (hs_cnt !== 1000 || m_axis_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL full_rate_count: got %0d beats v=%b, need 1000 beats v=0", hs_cnt, m_axis_tvalid);
    end
    bad = 0;
    for (int i = 0; i < rx_q.size(); i++) begin
      if (rx_q[i] !== 24'h100000 + DW'(i)) bad++;
    end
    checks++;
    if (bad != 0 || rx_q.size() != 1000) begin
      errors++;
      $display("FAIL full_rate_data: got %0d bad of %0d words, need 0 bad of 1000", bad, rx_q.size());
    end
  endtask

  task automatic test_backpressure();
    int bad;
    do_reset();
    load(24'h00AA00, 10);
    @(posedge clk);
    #1 hold_empty = 1'b0;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      @(negedge clk);
      if (c >= 2 && (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 24'h00AA00)) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_hold: got %0d bad cycles, need 0 (v=1 d=00aa00)", bad);
    end
    @(posedge clk);
    #1;
    checks++;
    if (rd_cnt !== 3) begin
      errors++;
      $display("FAIL bp_reads: got %0d fifo_rd pulses, need 3", rd_cnt);
    end
    m_axis_tready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      @(negedge clk);
      checks++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 24'h00AA00 + DW'(c)) begin
        errors++;
        $display("FAIL bp_drain beat%0d: got v=%b d=%h, need v=1 d=%h",
                 c, m_axis_tvalid, m_axis_tdata, 24'h00AA00 + DW'(c));
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (hs_cnt !== 10 || m_axis_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL bp_end: got %0d beats v=%b, need 10 beats v=0", hs_cnt, m_axis_tvalid);
    end
  endtask

  task automatic test_random();
    int bad;
    do_reset();
    load(24'h050000, 200);
    for (int c = 0; c < 3000 && hs_cnt < 200; c++) begin
      @(posedge clk);
      #1;
      hold_empty    = ($urandom_range(0, 3) == 0);
      m_axis_tready = $urandom_range(0, 1) != 0;
    end
    m_axis_tready = 1'b0;
    hold_empty = 1'b1;
    checks++;
    if (hs_cnt !== 200) begin
      errors++;
      $display("FAIL random_count: got %0d beats, need 200", hs_cnt);
    end
    bad = 0;
    for (int i = 0; i < rx_q.size(); i++) begin
      if (rx_q[i] !== 24'h050000 + DW'(i)) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL random_data: got %0d out-of-order words, need 0", bad);
    end
  endtask

`ifdef NATIVEFIFO2AXIS_TLAST_EN
  task automatic test_tlast();
    int bad;
    do_reset();
    load(24'h000001, 12);
    @(posedge clk);
    #1 hold_empty = 1'b0;
    for (int c = 0; c < 21; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      m_axis_tready = !(c >= 9 && c <= 11);
      @(negedge clk);
      if (c == 8) begin
        checks++;
        if (m_axis_tlast !== 1'b0 || m_axis_tdata !== 24'h000007) begin
          errors++;
          $display("FAIL tlast_beat6: got l=%b d=%h, need l=0 d=000007", m_axis_tlast, m_axis_tdata);
        end
      end
      if (c >= 9 && c <= 11) begin
        checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tlast !== 1'b1 || m_axis_tdata !== 24'h000008) begin
          errors++;
          $display("FAIL tlast_stall c%0d: got v=%b l=%b d=%h, need 1 1 000008",
                   c, m_axis_tvalid, m_axis_tlast, m_axis_tdata);
        end
      end
    end
    bad = 0;
    for (int i = 0; i < rx_q.size(); i++) begin
      if (rx_last[i] !== ((i % 4) == 3) || rx_q[i] !== DW'(i + 1)) bad++;
    end
    checks++;
    if (bad != 0 || rx_q.size() != 12) begin
      errors++;
      $display("FAIL tlast_pattern: got %0d bad of %0d beats, need 0 bad of 12", bad, rx_q.size());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_latency();
    test_full_rate();
    test_backpressure();
    test_random();
`ifdef NATIVEFIFO2AXIS_TLAST_EN
    test_tlast();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nativefifo2axis.md
Name: nativefifo2axis

Overview:
- Reader-side bridge: pops words from a standard-mode (non-FWFT) native FIFO and presents them as an AXI4-Stream master.
- Mirror of the AXI-Stream-to-FIFO write bridge in the LPDAQ data path; sits between the sample FIFO and downstream stream consumers (DMA, packetiser).
- Sustains 1 word/clk with no combinational path from m_axis_tready to fifo_rd.

Parameters:
- DW, 24, data width of FIFO word and m_axis_tdata.
- PKT_LEN, 256, beats per packet for TLAST generation; range 1..65535; used only with the optional feature.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset. Asserts immediately, releases synchronously to clk.
- fifo_dout  in  DW  FIFO read data; valid the cycle after fifo_rd.
- fifo_rd  out  1  FIFO read strobe; asserted only when fifo_empty=0.
- fifo_empty  in  1  FIFO empty flag.
- m_axis_tdata  out  DW  stream data, registered.
- m_axis_tvalid  out  1  stream valid, registered.
- m_axis_tready  in  1  stream ready.
- m_axis_tlast  out  1  end of packet; port exists only when NATIVEFIFO2AXIS_TLAST_EN is defined.

Behaviour:
- Reset values: fifo_rd=0 (combinational, forced low while rst_n=0), m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0.
- Reset also clears buffer occupancy (occ), the in-flight flag and the beat counter. A read in flight at reset is dropped; the FIFO must be reset together with this block.
- Internal 3-entry output buffer (skid FIFO). occ is in 0..3. inflight=1 if fifo_rd was asserted the previous cycle.
- fifo_rd = !fifo_empty && (occ + inflight) < 3. No dependence on m_axis_tready.
- Read latency:
  - fifo_rd in cycle N, then fifo_dout is captured into the buffer at the end of cycle N+1.
  - The word is visible on m_axis_* in cycle N+2 if the buffer was empty.
  - First-word latency from fifo_empty falling is therefore 2 clk.
- m_axis_tvalid = (occ != 0). m_axis_tdata = head entry. Both are driven from registers.
- Pop when m_axis_tvalid && m_axis_tready.
- Push and pop in the same cycle: occ unchanged, order preserved.
- AXI rules:
  - Once tvalid=1, tdata (and tlast) stay stable until accepted.
  - tvalid never drops without a handshake.
- Throughput: with tready held at 1 and the FIFO non-empty, 1 beat per clk in steady state (occ=1, inflight=1).
- Backpressure:
  - With tready=0, at most 3 words are drained from the FIFO, then fifo_rd stays 0.
  - When tready rises, no word is lost or duplicated.
- Empty: fifo_empty=1 means fifo_rd=0. The buffer drains normally, and tvalid falls the cycle after the last pop.
- Overflow of the buffer is impossible by construction. Verification asserts occ + inflight <= 3.

Optional Feature:
- Macro NATIVEFIFO2AXIS_TLAST_EN.
- Defined:
  - m_axis_tlast port present.
  - A 16-bit beat counter increments on each handshake.
  - tlast=1 on the beat where counter == PKT_LEN-1; the counter wraps to 0 after that handshake.
  - tlast is computed from the head beat's count and is stable while tvalid && !tready.
  - PKT_LEN=1 gives tlast=1 on every beat.
- Undefined: no port, no counter; plain unbounded stream.

Decomposition:
- Package nativefifo2axis_pkg holds:
  - BUF_DEPTH=3;
  - OCC_W=2 (occupancy width);
  - BEAT_CNT_W=16.
- One sub-module, axis_out_buf: 3-entry register FIFO with push/pop/occ and registered head output.
- The top level holds the fifo_rd issue logic, the inflight flag and the optional TLAST counter.

Test Plan:
- Reset: rst_n=0 mid-stream with 2 words buffered leads to tvalid=0 and fifo_rd=0 asynchronously. After release with fifo_empty=1, no activity.
- Latency: FIFO preloaded with 0x000001..0x000004, tready=1. fifo_empty falls at cycle 0, first tvalid at cycle 2, then 4 consecutive beats in order.
- Full rate: 1000 words, tready=1. Exactly 1000 handshakes in 1002 clk, data matches the incrementing pattern.
- Backpressure: tready=0 for 20 clk with 10 words in the FIFO. Exactly 3 fifo_rd pulses, tdata held at word 0. After tready=1, all 10 words arrive in order with no gaps.
- Random: tready toggling at 50% and fifo_empty random. Scoreboard shows no loss or duplication, and the occ + inflight <= 3 assertion holds.
- TLAST_EN with PKT_LEN=4: 12 words give tlast on beats 3, 7 and 11. tlast stays stable while tready=0 on beat 7.
